// File: rtl/maze_dfs_ctrl.sv
// maze_dfs_ctrl: depth-first-search sequencer for the maze-solver datapath, with solution replay.
// Inputs : clk, rst (async, active-low), start/run pulses, pos, edge_blk, cell_val, stk_rdata.
// Outputs: dir, datapath strobes (mem_rd, mem_wr, pos_ld, pos_back, clr, push), stk_addr,
//          rep_valid, and busy/done/fail status.
module maze_dfs_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEST_ADDR  = 2**8-1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] pos,
  input  logic                  edge_blk,
  input  logic                  cell_val,
  input  logic [1:0]            stk_rdata,
  output logic [1:0]            dir,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  pos_ld,
  output logic                  pos_back,
  output logic                  clr,
  output logic                  push,
  output logic [ADDR_WIDTH-1:0] stk_addr,
  output logic                  rep_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, INIT = 4'd1, CHECK = 4'd2, WAIT = 4'd3, MOVE = 4'd4,
    NEXT = 4'd5, BACK = 4'd6, DONE = 4'd7, REPLAY = 4'd8, FAIL = 4'd9
  } state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [1:0]            dir_q, dir_d;
  logic                  at_dest, sp_zero, rep_last;
  assign at_dest  = pos == ADDR_WIDTH'(DEST_ADDR);
  assign sp_zero  = sp_q == '0;
  assign rep_last = {1'b0, rp_q} == sp_q - 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sp_q    <= '0;
      rp_q    <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      rp_q    <= rp_d;
      dir_q   <= dir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    rp_d    = rp_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE:   state_d = start ? INIT : IDLE;
      INIT: begin
        sp_d    = '0;
        dir_d   = '0;
        state_d = CHECK;
      end
      CHECK:  state_d = at_dest ? DONE : edge_blk ? NEXT : WAIT;
      WAIT:   state_d = cell_val ? NEXT : MOVE;
      MOVE: begin
        sp_d    = sp_q + 1'b1;
        dir_d   = '0;
        state_d = CHECK;
      end
      NEXT: begin
        dir_d   = dir_q == 2'd3 ? dir_q : dir_q + 2'd1;
        state_d = dir_q == 2'd3 ? BACK : CHECK;
      end
      // a popped direction of 3 lands in NEXT with dir==3 and backtracks again
      BACK: begin
        dir_d   = sp_zero ? dir_q : stk_rdata;
        sp_d    = sp_zero ? sp_q : sp_q - 1'b1;
        state_d = sp_zero ? FAIL : NEXT;
      end
      DONE: begin
        rp_d    = '0;
        state_d = start ? INIT : (run && !sp_zero) ? REPLAY : DONE;
      end
      REPLAY: begin
        rp_d    = rp_q + 1'b1;
        state_d = rep_last ? DONE : REPLAY;
      end
      FAIL:   state_d = start ? INIT : FAIL;
      default: state_d = IDLE;
    endcase
  end
  // during a pop the datapath steps back along the stored move, so dir mirrors the stack
  assign dir       = (state_q == BACK && !sp_zero) ? stk_rdata : dir_q;
  assign mem_rd    = state_q == CHECK && !at_dest && !edge_blk;
  assign mem_wr    = state_q == MOVE;
  assign pos_ld    = state_q == MOVE;
  assign push      = state_q == MOVE;
  assign pos_back  = state_q == BACK && !sp_zero;
  assign clr       = state_q == INIT;
  assign stk_addr  = state_q == REPLAY ? rp_q : state_q == BACK ? sp_q[ADDR_WIDTH-1:0] - 1'b1 : sp_q[ADDR_WIDTH-1:0];
  assign rep_valid = state_q == REPLAY;
  assign busy      = !(state_q == IDLE || state_q == DONE || state_q == FAIL);
  assign done      = state_q == DONE || state_q == REPLAY;
  assign fail      = state_q == FAIL;
endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// tb_maze_dfs_ctrl: directed bench for maze_dfs_ctrl driving a 16x16 maze datapath model.
module tb_maze_dfs_ctrl;
  localparam logic [3:0] S_IDLE = 4'd0, S_INIT = 4'd1, S_CHECK = 4'd2, S_WAIT = 4'd3, S_MOVE = 4'd4;
  localparam logic [3:0] S_NEXT = 4'd5, S_BACK = 4'd6, S_DONE = 4'd7, S_REPLAY = 4'd8, S_FAIL = 4'd9;
  localparam int EMPTY_CYC = 1809;
  logic       clk = 0, rst = 0, start = 0, run = 0;
  logic [7:0] pos = 0;
  logic       edge_blk, cell_val = 0;
  logic [1:0] stk_rdata, dir;
  logic       mem_rd, mem_wr, pos_ld, pos_back, clr, push, rep_valid, busy, done, fail;
  logic [7:0] stk_addr;
  logic       maze [256];
  logic [1:0] stack [256];
  logic [1:0] mz_kind = 0;
  logic       mz_load = 0;
  logic [19:0] outs;
  int nvec = 0, nerr = 0;
  maze_dfs_ctrl #(.ADDR_WIDTH(8), .DEST_ADDR(255)) dut (
    .clk(clk), .rst(rst), .start(start), .run(run), .pos(pos), .edge_blk(edge_blk),
    .cell_val(cell_val), .stk_rdata(stk_rdata), .dir(dir), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pos_ld(pos_ld), .pos_back(pos_back), .clr(clr), .push(push), .stk_addr(stk_addr),
    .rep_valid(rep_valid), .busy(busy), .done(done), .fail(fail)
  );
  always #5 clk = ~clk;
  assign outs = {dir, mem_rd, mem_wr, pos_ld, pos_back, clr, push, stk_addr, rep_valid, busy, done, fail};
  function automatic logic [7:0] nbr(input logic [7:0] p, input logic [1:0] d);
    case (d)
      2'd0: return p - 8'd16;
      2'd1: return p + 8'd1;
      2'd2: return p - 8'd1;
      default: return p + 8'd16;
    endcase
  endfunction
  // kind 0 empty, 1 only cell 0 open, 2 dead-end row plus col 0 plus 255, 3 kind 2 plus bottom row and col 15
  function automatic logic open_cell(input logic [1:0] k, input logic [7:0] a);
    logic base;
    base = (a[7:4] == 4'd0 && a[3:0] <= 4'd3) || a[3:0] == 4'd0 || a == 8'd255;
    case (k)
      2'd0: return 1'b1;
      2'd1: return a == 8'd0;
      2'd2: return base;
      default: return base || a[7:4] == 4'd15 || a[3:0] == 4'd15;
    endcase
  endfunction
  assign edge_blk = (dir == 2'd0 && pos[7:4] == 4'd0) || (dir == 2'd1 && pos[3:0] == 4'd15) ||
                    (dir == 2'd2 && pos[3:0] == 4'd0) || (dir == 2'd3 && pos[7:4] == 4'd15);
  assign stk_rdata = stack[stk_addr];
  always @(posedge clk) begin
    if (mz_load) begin
      for (int i = 0; i < 256; i++) begin
        maze[i]  <= !open_cell(mz_kind, 8'(i));
        stack[i] <= 2'd0;
      end
    end else begin
      if (clr) begin
        pos     <= 8'd0;
        maze[0] <= 1'b1;
      end
      if (mem_rd) cell_val <= maze[nbr(pos, dir)];
      if (mem_wr) maze[nbr(pos, dir)] <= 1'b1;
      if (pos_ld) pos <= nbr(pos, dir);
      if (pos_back) pos <= nbr(pos, ~dir);
      if (push) stack[stk_addr] <= dir;
    end
  end
  task automatic load_maze(input logic [1:0] k);
    @(negedge clk);
    mz_kind = k;
    mz_load = 1;
    @(negedge clk);
    mz_load = 0;
  endtask
  task automatic run_solve(output int cyc, output int nback);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    nback = 0;
    while (!(done || fail) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (pos_back) nback++;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    nvec++; if (outs !== 20'd0) begin nerr++; $display("FAIL reset_outs: got %h want 0", outs); end
    nvec++; if (4'(dut.state_q) !== S_IDLE) begin nerr++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_IDLE); end
    rst = 1;
    @(negedge clk);
    run = 1;
    @(negedge clk);
    run = 0;
    @(negedge clk);
    nvec++; if (4'(dut.state_q) !== S_IDLE || outs !== 20'd0) begin nerr++; $display("FAIL idle_run: state %0d outs %h want IDLE/0", dut.state_q, outs); end
  endtask
  task automatic test_empty;
    int cyc, nb;
    load_maze(0);
    run_solve(cyc, nb);
    nvec++; if (done !== 1'b1 || fail !== 1'b0) begin nerr++; $display("FAIL empty_status: done %b fail %b want 1 0", done, fail); end
    nvec++; if (cyc != EMPTY_CYC) begin nerr++; $display("FAIL empty_cycles: got %0d want %0d", cyc, EMPTY_CYC); end
    nvec++; if (nb != 0) begin nerr++; $display("FAIL empty_backs: got %0d want 0", nb); end
    nvec++; if (pos !== 8'd255) begin nerr++; $display("FAIL empty_pos: got %0d want 255", pos); end
    nvec++; if (stk_addr !== 8'd240 || busy !== 1'b0) begin nerr++; $display("FAIL empty_sp: sp %0d busy %b want 240 0", stk_addr, busy); end
  endtask
  task automatic test_replay;
    int n, bad;
    logic [1:0] m;
    @(negedge clk);
    run = 1;
    @(negedge clk);
    run = 0;
    n = 0;
    bad = 0;
    while (rep_valid === 1'b1 && n < 300) begin
      m = (n % 16 == 15) ? 2'd3 : ((n / 16) % 2 == 0) ? 2'd1 : 2'd2;
      nvec++;
      if (stk_addr !== 8'(n) || stk_rdata !== m || done !== 1'b1 || busy !== 1'b1) begin
        nerr++;
        if (bad < 5) $display("FAIL replay_step %0d: addr %0d move %0d done %b want %0d %0d 1", n, stk_addr, stk_rdata, done, n, m);
        bad++;
      end
      n++;
      @(negedge clk);
    end
    nvec++; if (n != 240) begin nerr++; $display("FAIL replay_len: got %0d want 240", n); end
    nvec++; if (4'(dut.state_q) !== S_DONE || busy !== 1'b0 || done !== 1'b1) begin nerr++; $display("FAIL replay_end: state %0d busy %b want %0d 0", dut.state_q, busy, S_DONE); end
  endtask
  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    start = 1;
    run = 1;
    @(negedge clk);
    start = 0;
    run = 0;
    nvec++; if (4'(dut.state_q) !== S_INIT || clr !== 1'b1 || rep_valid !== 1'b0) begin nerr++; $display("FAIL start_run_done: state %0d clr %b want %0d 1", dut.state_q, clr, S_INIT); end
    cyc = 0;
    while (!(done || fail) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    nvec++; if (fail !== 1'b1 || stk_addr !== 8'd0) begin nerr++; $display("FAIL resolve_visited: fail %b sp %0d want 1 0", fail, stk_addr); end
  endtask
  task automatic test_wall;
    logic [3:0] seq [13];
    seq = '{S_INIT, S_CHECK, S_NEXT, S_CHECK, S_WAIT, S_NEXT, S_CHECK, S_NEXT, S_CHECK, S_WAIT, S_NEXT, S_BACK, S_FAIL};
    load_maze(1);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 13; i++) begin
      nvec++; if (4'(dut.state_q) !== seq[i]) begin nerr++; $display("FAIL wall_seq %0d: got %0d want %0d", i, dut.state_q, seq[i]); end
      @(negedge clk);
    end
    nvec++; if (fail !== 1'b1 || stk_addr !== 8'd0 || busy !== 1'b0) begin nerr++; $display("FAIL wall_end: fail %b sp %0d want 1 0", fail, stk_addr); end
  endtask
  task automatic test_dead_end;
    int cyc, nb;
    load_maze(2);
    run_solve(cyc, nb);
    nvec++; if (fail !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL dead_status: fail %b done %b want 1 0", fail, done); end
    nvec++; if (nb != 18) begin nerr++; $display("FAIL dead_backs: got %0d want 18", nb); end
    nvec++; if (pos !== 8'd0 || stk_addr !== 8'd0) begin nerr++; $display("FAIL dead_home: pos %0d sp %0d want 0 0", pos, stk_addr); end
  endtask
  task automatic test_dead_path;
    int cyc, nb, bad;
    load_maze(3);
    run_solve(cyc, nb);
    nvec++; if (done !== 1'b1 || pos !== 8'd255) begin nerr++; $display("FAIL path_status: done %b pos %0d want 1 255", done, pos); end
    nvec++; if (stk_addr !== 8'd30 || nb != 3) begin nerr++; $display("FAIL path_sp: sp %0d backs %0d want 30 3", stk_addr, nb); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      nvec++;
      if (stack[i] !== (i < 15 ? 2'd3 : 2'd1)) begin
        nerr++;
        if (bad < 5) $display("FAIL path_stack %0d: got %0d want %0d", i, stack[i], i < 15 ? 3 : 1);
        bad++;
      end
    end
  endtask
  task automatic test_reset_mid;
    int cyc, nb;
    load_maze(0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (push !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    nvec++; if (4'(dut.state_q) !== S_MOVE) begin nerr++; $display("FAIL mid_reach_move: got %0d want %0d", dut.state_q, S_MOVE); end
    rst = 0;
    #1;
    nvec++; if (outs !== 20'd0) begin nerr++; $display("FAIL mid_async_outs: got %h want 0", outs); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    nvec++; if (4'(dut.state_q) !== S_IDLE || busy !== 1'b0) begin nerr++; $display("FAIL mid_idle: state %0d want %0d", dut.state_q, S_IDLE); end
    load_maze(0);
    run_solve(cyc, nb);
    nvec++; if (done !== 1'b1 || cyc != EMPTY_CYC || stk_addr !== 8'd240) begin nerr++; $display("FAIL mid_resolve: done %b cyc %0d sp %0d want 1 %0d 240", done, cyc, stk_addr, EMPTY_CYC); end
  endtask
  task automatic test_ignore;
    int cyc;
    logic [3:0] st1;
    load_maze(0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    st1 = 4'hf;
    while (!(done || fail) && cyc < 5000) begin
      if (cyc == 1) st1 = 4'(dut.state_q);
      start = (cyc == 1);
      run = (cyc == 100);
      @(negedge clk);
      cyc++;
    end
    start = 0;
    run = 0;
    nvec++; if (st1 !== S_CHECK) begin nerr++; $display("FAIL ign_check_state: got %0d want %0d", st1, S_CHECK); end
    nvec++; if (done !== 1'b1 || cyc != EMPTY_CYC || stk_addr !== 8'd240 || pos !== 8'd255) begin nerr++; $display("FAIL ign_complete: done %b cyc %0d sp %0d want 1 %0d 240", done, cyc, stk_addr, EMPTY_CYC); end
  endtask
  initial begin
    test_reset;
    test_empty;
    test_replay;
    test_back_to_back;
    test_wall;
    test_dead_end;
    test_dead_path;
    test_reset_mid;
    test_ignore;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
